// File: rtl/stream_tg_chk.sv
// Stream traffic generator and checker: drives an incrementing count into a
// device under test and verifies that the returned stream matches it beat for beat.
module stream_tg_chk #(
  parameter int          num_bits  = 127,
  parameter int          cnt_w     = 32,
  parameter logic [15:0] lfsr_seed = 16'hACE1,
  parameter int          timeout   = 1024
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [1:0]          src_mode,
  input  logic [1:0]          snk_mode,
  input  logic [cnt_w-1:0]    num_beats,
  output logic                s1i_valid,
  input  logic                s1i_rdy,
  output logic [num_bits-1:0] s1i_data,
  input  logic                s1o_valid,
  output logic                s1o_rdy,
  input  logic [num_bits-1:0] s1o_data,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic                timed_out,
  output logic [cnt_w-1:0]    err_count,
  output logic [cnt_w-1:0]    first_err_idx,
  output logic [num_bits-1:0] first_err_data,
  output logic [num_bits-1:0] last_data,
  output logic [1:0]          dbg_state
);

  // Both streams: a beat transfers on a rising edge where valid and rdy are both
  // high; once valid is raised, valid and data stay unchanged until that beat.
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t           state;
  logic [cnt_w-1:0] nb;
  logic [cnt_w-1:0] tx_cnt;
  logic [cnt_w-1:0] rx_cnt;
  logic [15:0]      lfsr;
  logic [15:0]      to_cnt;
  logic             alt;

  logic             active;
  logic             src_gate;
  logic             snk_gate;
  logic             in_beat;
  logic             out_beat;
  logic             mismatch;
  logic             to_hit;
  logic             lfsr_fb;
  logic [cnt_w-1:0] tx_nxt;
  logic [cnt_w-1:0] rx_nxt;
  logic [cnt_w-1:0] err_nxt;

  always_comb begin
    active = (state == RUN) || (state == DRAIN);
    case (src_mode)
      2'd0:    src_gate = 1'b1;
      2'd1:    src_gate = alt;
      2'd2:    src_gate = lfsr[0];
      default: src_gate = 1'b0;
    endcase
    case (snk_mode)
      2'd0:    snk_gate = 1'b1;
      2'd1:    snk_gate = alt;
      2'd2:    snk_gate = lfsr[8];
      default: snk_gate = 1'b0;
    endcase
    in_beat  = s1i_valid && s1i_rdy;
    out_beat = s1o_valid && s1o_rdy;
    tx_nxt   = tx_cnt + cnt_w'(in_beat);
    rx_nxt   = rx_cnt + cnt_w'(out_beat);
    mismatch = out_beat && (s1o_data != num_bits'(rx_cnt));
    err_nxt  = err_count;
    if (mismatch && (err_count != '1)) err_nxt = err_count + cnt_w'(1);
    to_hit   = !in_beat && !out_beat && (to_cnt == 16'(timeout - 1));
    // Fibonacci taps 16,14,13,11 in right-shift form
    lfsr_fb  = lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5];
  end

  assign s1o_rdy   = active && snk_gate;
  assign s1i_data  = num_bits'(tx_cnt);
  assign busy      = active;
  assign done      = (state == DONE);
  assign dbg_state = state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= IDLE;
      nb             <= '0;
      tx_cnt         <= '0;
      rx_cnt         <= '0;
      lfsr           <= lfsr_seed;
      to_cnt         <= '0;
      alt            <= 1'b1;
      s1i_valid      <= 1'b0;
      pass           <= 1'b0;
      timed_out      <= 1'b0;
      err_count      <= '0;
      first_err_idx  <= '0;
      first_err_data <= '0;
      last_data      <= '0;
    end else begin
      if (active) begin
        lfsr <= {lfsr_fb, lfsr[15:1]};
        alt  <= ~alt;
      end
      if (out_beat) last_data <= s1o_data;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            nb             <= num_beats;
            tx_cnt         <= '0;
            rx_cnt         <= '0;
            err_count      <= '0;
            first_err_idx  <= '0;
            first_err_data <= '0;
            timed_out      <= 1'b0;
            to_cnt         <= '0;
            alt            <= 1'b1;
            s1i_valid      <= 1'b0;
            if (num_beats == '0) begin
              state <= DONE;
              pass  <= 1'b1;
            end else begin
              state <= RUN;
              pass  <= 1'b0;
            end
          end
        end
        RUN, DRAIN: begin
          tx_cnt    <= tx_nxt;
          rx_cnt    <= rx_nxt;
          err_count <= err_nxt;
          if (mismatch && (err_count == '0)) begin
            first_err_idx  <= rx_cnt;
            first_err_data <= s1o_data;
          end
          to_cnt <= (in_beat || out_beat) ? 16'd0 : to_cnt + 16'd1;
          // Completion wins over the last input beat landing in the same cycle
          if (rx_nxt == nb) begin
            state     <= DONE;
            pass      <= (err_nxt == '0);
            s1i_valid <= 1'b0;
          end else if (to_hit) begin
            state     <= DONE;
            timed_out <= 1'b1;
            pass      <= 1'b0;
            s1i_valid <= 1'b0;
          end else begin
            if ((state == RUN) && (tx_nxt == nb)) state <= DRAIN;
            if (!(s1i_valid && !s1i_rdy))
              s1i_valid <= (state == RUN) && (tx_nxt < nb) && src_gate;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/stream_tg_chk.md
Name: stream_tg_chk

Overview:
- Parametrised stream traffic generator plus checker for exercising a valid/rdy firmware stream block such as inter.
- Drives an incrementing-count stream into the DUT input, accepts the DUT output stream, and checks each beat against the expected sequence.
- The DUT is treated as identity: output beat k equals input beat k.
- Adds programmable source gaps, sink backpressure, run length, error capture and a stall timeout.

Parameters:
- num_bits, 127, stream data width.
- cnt_w, 32, width of beat counters and num_beats.
- lfsr_seed, 16'hACE1, non-zero LFSR reset value.
- timeout, 1024, idle cycles without any handshake before the run aborts; range 1..65535.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  pulse; begins a run when sampled in IDLE or DONE.
- src_mode  in  2  source valid policy: 0 always, 1 alternate cycles, 2 LFSR bit 0, 3 never.
- snk_mode  in  2  sink rdy policy: 0 always, 1 alternate cycles, 2 LFSR bit 8, 3 never.
- num_beats  in  cnt_w  beats per run; sampled on start.
- s1i_valid  out  1  to DUT input stream.
- s1i_rdy  in  1  from DUT.
- s1i_data  out  num_bits  to DUT.
- s1o_valid  in  1  from DUT output stream.
- s1o_rdy  out  1  to DUT.
- s1o_data  in  num_bits  from DUT.
- busy  out  1  high in RUN or DRAIN.
- done  out  1  high in DONE.
- pass  out  1  valid when done: no errors and no timeout.
- timed_out  out  1  run ended by timeout.
- err_count  out  cnt_w  mismatching beats; saturates at all-ones.
- first_err_idx  out  cnt_w  beat index of the first mismatch.
- first_err_data  out  num_bits  received data of the first mismatch.
- last_data  out  num_bits  data of the most recent accepted output beat.

Behaviour:
- Reset: every output 0, FSM in IDLE, LFSR = lfsr_seed, all counters 0.
- Handshakes:
  - Input beat: s1i_valid & s1i_rdy on a rising edge.
  - Output beat: s1o_valid & s1o_rdy on a rising edge.
- FSM states: IDLE, RUN, DRAIN, DONE.
- Start:
  - start in IDLE or DONE latches num_beats, clears tx_cnt, rx_cnt, err_count, first_err_*, timed_out, pass and the timeout counter, then moves to RUN next cycle.
  - start in RUN or DRAIN is ignored.
  - num_beats = 0: go straight to DONE with pass = 1.
- Source (RUN only):
  - s1i_data = tx_cnt[num_bits-1:0], wrapping modulo 2^num_bits.
  - s1i_valid rises only when the src_mode gate is true.
  - Once raised, s1i_valid and s1i_data hold stable until the input beat completes, regardless of the gate.
  - tx_cnt increments on each input beat.
  - After the beat making tx_cnt = num_beats, s1i_valid is 0 from the next cycle.
- Mode gates:
  - Mode 1 toggles every cycle in RUN/DRAIN, starting true.
  - Modes 0 and 3 are constant (always / never).
- LFSR:
  - 16-bit Fibonacci, taps 16, 14, 13, 11.
  - Advances every cycle in RUN and DRAIN; holds otherwise.
- Sink:
  - s1o_rdy = snk gate in RUN and DRAIN; 0 in IDLE and DONE.
  - On each output beat: compare s1o_data with rx_cnt[num_bits-1:0].
  - On mismatch: increment err_count (saturating); if it was 0, capture first_err_idx = rx_cnt and first_err_data = s1o_data.
  - last_data <= s1o_data on every output beat.
  - rx_cnt increments on every output beat, match or not.
- Transitions:
  - RUN -> DRAIN when tx_cnt reaches num_beats.
  - RUN or DRAIN -> DONE when rx_cnt reaches num_beats. This may happen in the same cycle as the last input beat (zero-latency DUT); DONE then takes priority.
  - DONE: pass = (err_count == 0) & ~timed_out, registered on entry.
- Timeout:
  - Counter runs in RUN and DRAIN; it clears on any input or output beat.
  - When it reaches timeout: go to DONE, timed_out = 1, pass = 0.
- Reset mid-run: immediate return to reset values; the DUT sees valid/rdy drop asynchronously.
- DONE holds all results until the next start.

Test Plan:
- src_mode = 0, snk_mode = 0, num_beats = 16, zero-latency loopback (s1o = s1i): DONE after 16 beats, pass = 1, err_count = 0, last_data = 15.
- src_mode = 2, snk_mode = 2, num_beats = 1000, inter DUT: s1i_data stable while stalled (assertion), pass = 1, last_data = 999.
- Loopback with bit 0 of beat 5 inverted: err_count = 1, first_err_idx = 5, first_err_data = 4, pass = 0, rx_cnt = num_beats.
- snk_mode = 3, num_beats = 4, timeout = 1024: DONE with timed_out = 1, pass = 0, entered 1024 cycles after the last input beat.
- num_beats = 0 then start: DONE with pass = 1 on the next cycle, no s1i_valid pulse.
- rst low during RUN at beat 7: all outputs 0 immediately; after a new start, tx restarts at data 0, and a start pulse while busy has no effect.
